// File: rtl/pool_flatten_buffer.sv
// Ping-pong capture buffer for pooled 3-channel feature maps.
// Each full map is replayed as a channel-major flattened valid/ready stream.
module pool_flatten_buffer #(
  parameter int DATA_BIT = 12,
  parameter int MAP_W    = 4,
  parameter int MAP_H    = 4,
  parameter int CH       = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  input  logic [DATA_BIT-1:0] data_in_1,
  input  logic [DATA_BIT-1:0] data_in_2,
  input  logic [DATA_BIT-1:0] data_in_3,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_BIT-1:0] out_data,
  output logic [5:0]          out_index,
  output logic                out_last,
  output logic                overflow
);

  localparam int PIX   = MAP_W * MAP_H;
  localparam int DEPTH = CH * PIX;
  localparam int PIX_W = $clog2(PIX);

  logic [DATA_BIT-1:0] mem_q [2][DEPTH];

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [PIX_W-1:0] wr_pix_q, wr_pix_d;
  logic [5:0]       rd_idx_q, rd_idx_d;
  logic             overflow_q, overflow_d;
  logic             accept;
  logic             xfer;

  // A bank can never be written and released in the same cycle: writes need
  // it empty, reads need it full, so the two full_d updates never collide.
  always_comb begin
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_pix_d   = wr_pix_q;
    rd_idx_d   = rd_idx_q;
    overflow_d = overflow_q;
    accept     = valid_in & ~full_q[wr_bank_q];
    xfer       = full_q[rd_bank_q] & out_ready;

    if (accept) begin
      if (wr_pix_q == PIX_W'(PIX - 1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_pix_d          = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_pix_d = wr_pix_q + 1'b1;
      end
    end
    if (valid_in && full_q[wr_bank_q]) begin
      overflow_d = 1'b1;
    end

    if (xfer) begin
      if (rd_idx_q == 6'(DEPTH - 1)) begin
        rd_idx_d          = '0;
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end else begin
        rd_idx_d = rd_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_pix_q   <= '0;
      rd_idx_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_pix_q   <= wr_pix_d;
      rd_idx_q   <= rd_idx_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately unreset; channel k lands in the k-th PIX-sized slice.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_bank_q][6'(wr_pix_q)]              <= data_in_1;
      mem_q[wr_bank_q][6'(wr_pix_q) + 6'(PIX)]     <= data_in_2;
      mem_q[wr_bank_q][6'(wr_pix_q) + 6'(2 * PIX)] <= data_in_3;
    end
  end

  // out_data is forced to zero when idle so reset and empty states read clean.
  assign out_valid = full_q[rd_bank_q];
  assign out_index = rd_idx_q;
  assign out_last  = out_valid & (rd_idx_q == 6'(DEPTH - 1));
  assign out_data  = out_valid ? mem_q[rd_bank_q][rd_idx_q] : '0;
  assign overflow  = overflow_q;

endmodule

// File: doc/pool_flatten_buffer.md
Name: pool_flatten_buffer

Overview:
- Consumer end of the max-pool/ReLU output stream.
- Collects each pooled, ReLU'd MAP_H x MAP_W x CH feature map into one of two ping-pong banks.
- Replays the stored map as a flattened, channel-major, one-element-per-cycle stream with valid/ready handshake to the fully connected stage.
- The pool side has no backpressure, so the block absorbs it by double buffering and flags any loss.

Parameters:
DATA_BIT, 12, width of each pooled value (unsigned, post-ReLU)
MAP_W, 4, pooled map width
MAP_H, 4, pooled map height
CH, 3, channels per pixel (fixed to three input lanes)
DEPTH, CH*MAP_W*MAP_H = 48, elements per flattened map (derived; not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
valid_in  in  1  pooled pixel present on data_in_1..3 this cycle
data_in_1  in  DATA_BIT  channel 1 pooled value
data_in_2  in  DATA_BIT  channel 2 pooled value
data_in_3  in  DATA_BIT  channel 3 pooled value
out_valid  out  1  out_data holds a valid flattened element
out_ready  in  1  downstream accepts element
out_data  out  DATA_BIT  flattened element
out_index  out  6  flat index of out_data, 0..DEPTH-1
out_last  out  1  high with element DEPTH-1 of a map
overflow  out  1  sticky: a pixel was dropped

Behaviour:
- Reset (async, rst=1): all outputs 0, wr_bank=0, rd_bank=0, wr_pix=0, rd_idx=0, both bank_full flags 0. Bank contents are not reset.
- Write side, accept condition: valid_in=1 and bank_full[wr_bank]=0 (registered flag, sampled this cycle).
- On accept: store data_in_k at bank[wr_bank][(k-1)*MAP_W*MAP_H + wr_pix] for k=1..3, all in the same edge.
- wr_pix counts 0..15 in row-major pixel order.
- On accept at wr_pix=15: bank_full[wr_bank]<=1, wr_pix<=0, wr_bank toggles.
- Reject (valid_in=1, bank full): sample dropped, wr_pix/wr_bank unchanged, overflow<=1 (cleared only by rst).
- valid_in=0: no change.
- Read side: out_valid = bank_full[rd_bank]. out_index = rd_idx. out_data = bank[rd_bank][rd_idx]. out_last = out_valid & (rd_idx==DEPTH-1). All driven from registers, no combinational path from inputs.
- Transfer: out_valid & out_ready. rd_idx<=rd_idx+1.
- Transfer at rd_idx=DEPTH-1: rd_idx<=0, bank_full[rd_bank]<=0, rd_bank toggles.
- While out_valid=1 and out_ready=0, out_data/out_index/out_last hold stable.
- Latency: 16th accepted pixel at edge T → out_valid=1 after edge T (first element visible in cycle T+1) when the read side is idle on that bank. Streaming throughput 1 element/cycle.
- Drain duration: a full map needs 48 ready cycles; input arrives at most every cycle.
- Simultaneous: write completing bank A while reading bank B is legal. Release of a bank and first write into it in the same cycle: write sees the old flag (full) → rejected, overflow set.
- Partial map: wr_pix holds its position indefinitely; there is no timeout.
- Reset mid-operation: any partial write map and partial drain are discarded. Next accepted pixel goes to bank 0, index 0.

Test Plan:
- Single map, out_ready=1: 16 pixels ch1=p, ch2=100+p, ch3=200+p (p=0..15), valid_in every other cycle → 48 outputs in order 0..15, 100..115, 200..215; out_index 0..47; out_last only on 215; out_valid rises one cycle after 16th pixel; overflow=0.
- Backpressure: same map, out_ready pseudo-random 50% → identical sequence, out_data/out_index stable on every stalled cycle, no duplicates or skips.
- Ping-pong: out_ready=0, maps A (values 1..) and B (values 500..) back-to-back, then out_ready=1 → all of A then all of B, two out_last pulses, overflow=0.
- Overflow: out_ready=0, three maps sent → all 16 third-map pixels dropped, overflow=1 from first drop, then draining yields only A and B intact.
- Release collision: final A element transferred in the same cycle the first pixel of map C arrives with B full → C pixel 0 dropped, overflow=1.
- Reset mid-drain: rst pulse after 20 transfers → out_valid=0, overflow=0 immediately (async). Next map appears from index 0 in bank 0 with correct values.
